clk_divider_mc: RTL and testbench

Multi-channel programmable clock divider, the parametrised successor to the single-channel divider in the PLL wrapper. It derives `CH` independent divided clocks from `clk_in`. Each channel has its own N-bit divide ratio, enable and tick strobe. Ratio changes are accepted through a valid/ready write port and take effect only at a period boundary, so no runt pulses appear. A shared `sync` input phase-aligns all channels.

---
 rtl/clk_divider_mc_if.sv | 17 +
 rtl/clk_divider_mc.sv | 166 ++++++++++++++++
 tb/tb_clk_divider_mc.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_divider_mc_if.sv
// Ratio write port of the multi-channel clock divider.
// The master presents a ratio and a channel select; ready reflects whether
// the selected channel still holds an unapplied ratio.
interface clk_divider_mc_if #(
    parameter int N  = 8,
    parameter int CH = 2
);
    localparam int SW = (CH > 1) ? $clog2(CH) : 1;

    logic [N-1:0]  div_val;
    logic [SW-1:0] div_sel;
    logic          div_valid;
    logic          div_ready;

    modport master (output div_val, div_sel, div_valid, input  div_ready);
    modport slave  (input  div_val, div_sel, div_valid, output div_ready);
endinterface

// File: rtl/clk_divider_mc.sv
// Multi-channel programmable clock divider.
// Each channel divides clk_in by its own ratio. New ratios wait in a
// one-deep pending slot and only take effect at a period boundary, so the
// divided clock never produces a runt period. A shared sync input forces a
// boundary on every running channel at once, phase-aligning them.

// One divider channel: ratio registers, period counter, registered clock and tick.
module clk_divider_ch #(
    parameter int N         = 8,
    parameter int RESET_DIV = 4
) (
    input  logic         clk_in,
    input  logic         rst_n,
    input  logic         en,
    input  logic         sync,
    input  logic         load,
    input  logic [N-1:0] load_val,
    output logic         pend_v,
    output logic         clk_out,
    output logic         tick,
    output logic         active
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [N-1:0] ONE = N'(1);

    state_t       state, state_nxt;
    logic [N-1:0] cnt, cnt_nxt;
    logic [N-1:0] div_act, div_act_nxt;
    logic [N-1:0] pend, pend_nxt;
    logic         pend_v_nxt;
    logic         q, q_nxt;
    logic         tick_r, tick_nxt;
    logic         pass, pass_nxt;
    logic [N-1:0] ratio_eff;
    logic         boundary;

    // Next-state: IDLE/RUN control, period counter, pending-ratio apply and write capture.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        div_act_nxt = div_act;
        pend_nxt    = pend;
        pend_v_nxt  = pend_v;
        q_nxt       = 1'b0;
        tick_nxt    = 1'b0;
        boundary    = 1'b0;
        // The ratio that will be in use after a boundary: a pending one wins.
        ratio_eff   = pend_v ? pend : div_act;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (pend_v) begin
                    div_act_nxt = pend;
                    pend_v_nxt  = 1'b0;
                end
                if (en && ratio_eff != '0)
                    state_nxt = RUN;
            end
            RUN: begin
                // Outputs lag the counter by one cycle: high for the first D/2 counts.
                q_nxt    = (cnt < (div_act >> 1));
                tick_nxt = (cnt == '0);
                boundary = sync || (cnt == div_act - ONE);
                if (boundary) begin
                    cnt_nxt = '0;
                    if (pend_v) begin
                        div_act_nxt = pend;
                        pend_v_nxt  = 1'b0;
                    end
                    if (!en || ratio_eff == '0)
                        state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + ONE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A write is only offered while the slot is empty, so it never races an apply.
        if (load) begin
            pend_nxt   = load_val;
            pend_v_nxt = 1'b1;
        end

        // Passthrough gate tracks the post-edge state so it opens and closes on a rising edge.
        pass_nxt = (state_nxt == RUN) && (div_act_nxt == ONE);
    end

    // State register with asynchronous reset back to the default ratio.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            div_act <= N'(RESET_DIV);
            pend    <= '0;
            pend_v  <= 1'b0;
            q       <= 1'b0;
            tick_r  <= 1'b0;
            pass    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            div_act <= div_act_nxt;
            pend    <= pend_nxt;
            pend_v  <= pend_v_nxt;
            q       <= q_nxt;
            tick_r  <= tick_nxt;
            pass    <= pass_nxt;
        end
    end

    // Ratio 1 has no room for a registered half period, so gate clk_in directly.
    assign clk_out = q | (clk_in & pass);
    assign tick    = tick_r;
    assign active  = (state == RUN);
endmodule

module clk_divider_mc #(
    parameter int N         = 8,
    parameter int CH        = 2,
    parameter int RESET_DIV = 4
) (
    input  logic            clk_in,
    input  logic            rst_n,
    input  logic [CH-1:0]   en,
    input  logic            sync,
    clk_divider_mc_if.slave wr,
    output logic [CH-1:0]   clk_out,
    output logic [CH-1:0]   tick,
    output logic [CH-1:0]   active
);
    localparam int SW = (CH > 1) ? $clog2(CH) : 1;

    logic [CH-1:0] pend_v;
    logic [CH-1:0] load;

    // Ready follows the selected channel's pending slot; an out-of-range select reads ready and is dropped.
    always_comb begin
        wr.div_ready = 1'b1;
        for (int i = 0; i < CH; i++)
            if (wr.div_sel == SW'(i))
                wr.div_ready = !pend_v[i];
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        assign load[g] = wr.div_valid && (wr.div_sel == SW'(g)) && !pend_v[g];

        clk_divider_ch #(
            .N         (N),
            .RESET_DIV (RESET_DIV)
        ) u_ch (
            .clk_in   (clk_in),
            .rst_n    (rst_n),
            .en       (en[g]),
            .sync     (sync),
            .load     (load[g]),
            .load_val (wr.div_val),
            .pend_v   (pend_v[g]),
            .clk_out  (clk_out[g]),
            .tick     (tick[g]),
            .active   (active[g])
        );
    end
endmodule

// File: tb/tb_clk_divider_mc.sv
// Bench for clk_divider_mc: reset/ratio-change table, hand sequences for
// sync, passthrough, zero ratio, disable and async reset, then random traffic
// checked cycle by cycle against a period-position model.
module tb_clk_divider_mc;
    localparam int N         = 8;
    localparam int CH        = 2;
    localparam int RESET_DIV = 4;

    logic          clk_in = 1'b0;
    logic          rst_n;
    logic [CH-1:0] en;
    logic          sync;
    logic [CH-1:0] clk_out, tick, active;

    clk_divider_mc_if #(.N(N), .CH(CH)) wr_if ();

    clk_divider_mc #(.N(N), .CH(CH), .RESET_DIV(RESET_DIV)) dut (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .en      (en),
        .sync    (sync),
        .wr      (wr_if),
        .clk_out (clk_out),
        .tick    (tick),
        .active  (active)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    // Model: per channel, whether it runs, how many cycles into the period it is,
    // the ratio in use, the pending ratio, and the registered outputs.
    bit m_run  [CH];
    int m_pos  [CH];
    int m_d    [CH];
    int m_pend [CH];
    bit m_pv   [CH];
    bit m_q    [CH];
    bit m_tick [CH];
    bit m_pass [CH];

    logic [CH-1:0] lo_clk;
    logic          rdy_s;

    typedef struct packed {
        logic [CH-1:0] en;
        logic          v;
        logic [N-1:0]  val;
        logic          rdy;
        logic [CH-1:0] act;
        logic [CH-1:0] tck;
        logic [CH-1:0] clk;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mk(logic [CH-1:0] e, logic v, logic [N-1:0] val, logic rdy,
                                logic [CH-1:0] act, logic [CH-1:0] tck, logic [CH-1:0] clk);
        vec_t r;
        r.en = e; r.v = v; r.val = val; r.rdy = rdy; r.act = act; r.tck = tck; r.clk = clk;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_run[c] = 0; m_pos[c] = 0; m_d[c] = RESET_DIV; m_pend[c] = 0;
            m_pv[c] = 0;  m_q[c] = 0;   m_tick[c] = 0;      m_pass[c] = 0;
        end
    endtask

    task automatic model_step(input logic [CH-1:0] e, input logic s, input logic v,
                              input int val, input int sel);
        for (int c = 0; c < CH; c++) begin
            bit take;
            bit at_end;
            take = v && (sel == c) && !m_pv[c];
            if (m_run[c]) begin
                m_q[c]    = (m_pos[c] < m_d[c] / 2);
                m_tick[c] = (m_pos[c] == 0);
                at_end    = s || (m_pos[c] == m_d[c] - 1);
                if (at_end) begin
                    m_pos[c] = 0;
                    if (m_pv[c]) begin m_d[c] = m_pend[c]; m_pv[c] = 0; end
                    if (!e[c] || m_d[c] == 0) m_run[c] = 0;
                end else begin
                    m_pos[c] = m_pos[c] + 1;
                end
            end else begin
                m_q[c] = 0; m_tick[c] = 0; m_pos[c] = 0;
                if (m_pv[c]) begin m_d[c] = m_pend[c]; m_pv[c] = 0; end
                if (e[c] && m_d[c] != 0) m_run[c] = 1;
            end
            if (take) begin m_pend[c] = val; m_pv[c] = 1; end
            m_pass[c] = m_run[c] && (m_d[c] == 1);
        end
    endtask

    function automatic logic [CH-1:0] exp_q();
        logic [CH-1:0] r;
        for (int c = 0; c < CH; c++) r[c] = m_q[c];
        return r;
    endfunction

    function automatic logic [CH-1:0] exp_hi();
        logic [CH-1:0] r;
        for (int c = 0; c < CH; c++) r[c] = m_q[c] | m_pass[c];
        return r;
    endfunction

    function automatic logic [CH-1:0] exp_tick();
        logic [CH-1:0] r;
        for (int c = 0; c < CH; c++) r[c] = m_tick[c];
        return r;
    endfunction

    function automatic logic [CH-1:0] exp_act();
        logic [CH-1:0] r;
        for (int c = 0; c < CH; c++) r[c] = m_run[c];
        return r;
    endfunction

    function automatic logic m_ready(input int sel);
        return (sel < CH) ? !m_pv[sel] : 1'b1;
    endfunction

    // One clk_in cycle: drive at the falling edge, check low phase and ready,
    // step the model at the rising edge, check high phase just after it.
    task automatic cyc(input logic [CH-1:0] e, input logic s, input logic v,
                       input logic [N-1:0] val, input logic sel);
        @(negedge clk_in);
        en = e; sync = s;
        wr_if.div_valid = v; wr_if.div_val = val; wr_if.div_sel = sel;
        #1;
        lo_clk = clk_out;
        rdy_s  = wr_if.div_ready;
        chk("clk_out_low", lo_clk, exp_q());
        chk("div_ready", rdy_s, m_ready(int'(sel)));
        @(posedge clk_in);
        model_step(e, s, v, int'(val), int'(sel));
        #1;
        chk("active", active, exp_act());
        chk("tick", tick, exp_tick());
        chk("clk_out_high", clk_out, exp_hi());
    endtask

    // Every tick gap on a channel must equal the period, and a window of whole periods holds exactly that many ticks.
    task automatic tick_spacing(input string name, input int ch, input logic [CH-1:0] e,
                                input int ncyc, input int period);
        int last;
        int seen;
        last = -1;
        seen = 0;
        for (int i = 0; i < ncyc; i++) begin
            cyc(e, 1'b0, 1'b0, '0, 1'b0);
            if (tick[ch]) begin
                if (last >= 0) chk({name, "_gap"}, i - last, period);
                last = i;
                seen++;
            end
        end
        chk({name, "_count"}, seen, ncyc / period);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int n;
        logic [CH-1:0] ex;
        logic [CH-1:0] re;

        // Default ratio 4 on ch0, then ratio 7 written mid-period plus a rejected second write.
        tbl[0]  = mk(2'b01, 0, 8'd0, 1, 2'b01, 2'b00, 2'b00);
        tbl[1]  = mk(2'b01, 0, 8'd0, 1, 2'b01, 2'b01, 2'b01);
        tbl[2]  = mk(2'b01, 0, 8'd0, 1, 2'b01, 2'b00, 2'b01);
        tbl[3]  = mk(2'b01, 0, 8'd0, 1, 2'b01, 2'b00, 2'b00);
        tbl[4]  = mk(2'b01, 0, 8'd0, 1, 2'b01, 2'b00, 2'b00);
        tbl[5]  = mk(2'b01, 0, 8'd0, 1, 2'b01, 2'b01, 2'b01);
        tbl[6]  = mk(2'b01, 0, 8'd0, 1, 2'b01, 2'b00, 2'b01);
        tbl[7]  = mk(2'b01, 1, 8'd7, 1, 2'b01, 2'b00, 2'b00);
        tbl[8]  = mk(2'b01, 1, 8'd5, 0, 2'b01, 2'b00, 2'b00);
        tbl[9]  = mk(2'b01, 0, 8'd0, 1, 2'b01, 2'b01, 2'b01);
        tbl[10] = mk(2'b01, 0, 8'd0, 1, 2'b01, 2'b00, 2'b01);
        tbl[11] = mk(2'b01, 0, 8'd0, 1, 2'b01, 2'b00, 2'b01);
        tbl[12] = mk(2'b01, 0, 8'd0, 1, 2'b01, 2'b00, 2'b00);
        tbl[13] = mk(2'b01, 0, 8'd0, 1, 2'b01, 2'b00, 2'b00);
        tbl[14] = mk(2'b01, 0, 8'd0, 1, 2'b01, 2'b00, 2'b00);
        tbl[15] = mk(2'b01, 0, 8'd0, 1, 2'b01, 2'b00, 2'b00);
        tbl[16] = mk(2'b01, 0, 8'd0, 1, 2'b01, 2'b01, 2'b01);

        rst_n = 1'b1; en = '0; sync = 1'b0;
        wr_if.div_valid = 1'b0; wr_if.div_val = '0; wr_if.div_sel = '0;
        #2 rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_in);
        #1;
        chk("rst_clk_out", clk_out, 0);
        chk("rst_tick", tick, 0);
        chk("rst_active", active, 0);
        chk("rst_ready", wr_if.div_ready, 1);
        @(negedge clk_in);
        rst_n = 1'b1;

        for (int r = 0; r < 17; r++) begin
            cyc(tbl[r].en, 1'b0, tbl[r].v, tbl[r].val, 1'b0);
            chk($sformatf("tbl%0d_ready", r), rdy_s, tbl[r].rdy);
            chk($sformatf("tbl%0d_active", r), active, tbl[r].act);
            chk($sformatf("tbl%0d_tick", r), tick, tbl[r].tck);
            chk($sformatf("tbl%0d_clk", r), clk_out, tbl[r].clk);
        end

        // Sync: ch0 at 3, ch1 at 5, ticks aligned two edges after sync is driven.
        cyc(2'b11, 1'b0, 1'b1, 8'd3, 1'b0);
        cyc(2'b11, 1'b0, 1'b1, 8'd5, 1'b1);
        repeat (10) cyc(2'b11, 1'b0, 1'b0, '0, 1'b0);
        cyc(2'b11, 1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 15; i++) begin
            cyc(2'b11, 1'b0, 1'b0, '0, 1'b0);
            ex[0] = (i % 3 == 0);
            ex[1] = (i % 5 == 0);
            chk($sformatf("sync_tick%0d", i), tick, ex);
        end

        // Passthrough on ch1, then back to ratio 6.
        cyc(2'b11, 1'b0, 1'b1, 8'd1, 1'b1);
        repeat (7) cyc(2'b11, 1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(2'b11, 1'b0, 1'b0, '0, 1'b0);
            chk("pass_low", lo_clk[1], 0);
            chk("pass_high", clk_out[1], 1);
            chk("pass_tick", tick[1], 1);
        end
        cyc(2'b11, 1'b0, 1'b1, 8'd6, 1'b1);
        cyc(2'b11, 1'b0, 1'b0, '0, 1'b0);
        tick_spacing("div6", 1, 2'b11, 24, 6);

        // Ratio 0 written to running ch1: it finishes the period and idles.
        cyc(2'b11, 1'b0, 1'b1, 8'd0, 1'b1);
        for (k = 0; k < 10; k++) begin
            cyc(2'b11, 1'b0, 1'b0, '0, 1'b0);
            if (!active[1]) break;
        end
        chk("zero_idle", active[1], 0);
        chk("zero_clk", clk_out[1], 0);
        cyc(2'b11, 1'b0, 1'b0, '0, 1'b0);
        chk("zero_stays", {active[1], tick[1], clk_out[1]}, 0);

        // Disable ch0 at ratio 5 right after a tick: the period completes in full.
        cyc(2'b01, 1'b0, 1'b1, 8'd5, 1'b0);
        repeat (6) cyc(2'b01, 1'b0, 1'b0, '0, 1'b0);
        for (k = 0; k < 8; k++) begin
            cyc(2'b01, 1'b0, 1'b0, '0, 1'b0);
            if (tick[0]) break;
        end
        chk("drop_tick_seen", tick[0], 1);
        n = 0;
        for (k = 0; k < 10; k++) begin
            cyc(2'b00, 1'b0, 1'b0, '0, 1'b0);
            n++;
            if (!active[0]) break;
        end
        chk("drop_cycles", n, 4);

        // Async reset while clk_out[0] is high with a write pending.
        cyc(2'b01, 1'b0, 1'b0, '0, 1'b0);
        for (k = 0; k < 10; k++) begin
            cyc(2'b01, 1'b0, 1'b0, '0, 1'b0);
            if (tick[0]) break;
        end
        chk("rst_tick_seen", tick[0], 1);
        cyc(2'b01, 1'b0, 1'b1, 8'd9, 1'b0);
        chk("pre_rst_clk", clk_out[0], 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_clk_out", clk_out, 0);
        chk("mid_rst_active", active, 0);
        chk("mid_rst_tick", tick, 0);
        chk("mid_rst_ready", wr_if.div_ready, 1);
        model_reset();
        en = '0; wr_if.div_valid = 1'b0; sync = 1'b0;
        @(negedge clk_in);
        rst_n = 1'b1;
        tick_spacing("post_rst_div4", 0, 2'b01, 20, 4);

        // Random traffic against the model.
        re = 2'b11;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 15) == 0) re = CH'($urandom_range(0, 3));
            cyc(re, ($urandom_range(0, 31) == 0), ($urandom_range(0, 3) == 0),
                N'($urandom_range(0, 9)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
